uart_tx_ctrl: RTL and testbench
===============================

// Module: uart_tx_ctrl
// PURPOSE
//  UART transmit sequencer that drives the shared baud tick counter.
//  - Accepts one data word per valid/ready handshake.
//  - Enables the baud counter for the duration of a frame.
//  - Steps start/data/[parity]/stop bits on each baud_tick; LSB first.
//  - Sits between the NPU result/readback path and the serial pin.
// PARAMETERS
//  DATA_BITS   8  data bits per frame (5..9)
//  STOP_BITS   1  stop bits per frame (1 or 2)
//  PARITY_ODD  0  0 = even parity, 1 = odd; used only with UART_PARITY_EN
// PORTS
//  clk        in   1          clock
//  rst        in   1          reset, asynchronous, active-high
//  tx_data    in   DATA_BITS  word to send; sampled on accept
//  tx_valid   in   1          requester has a word
//  tx_ready   out  1          high only in IDLE; accept = tx_valid & tx_ready
//  baud_en    out  1          enable to baud counter; high for the whole frame
//  baud_tick  in   1          1-cycle pulse from counter; first pulse one bit period after baud_en rises
//  tx         out  1          serial line, idle high
//  busy       out  1          frame in progress (state != IDLE)
//  tx_done    out  1          1-cycle pulse when last stop bit completes
// BEHAVIOUR
//  - Reset (async): state=IDLE, tx=1, baud_en=0, busy=0, tx_done=0, bit_cnt=0, shift=0.
//    tx_ready is 1 after reset. Reset mid-frame aborts instantly (tx=1 in the same cycle as rst).
//  - All outputs are registered except tx_ready (decoded from the state register).
//  - States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//  - IDLE: on accept, shift<=tx_data, parity<=^tx_data^PARITY_ODD. Next cycle: START, tx=0, baud_en=1.
//  - START: on baud_tick -> DATA, tx<=shift[0], bit_cnt<=0.
//  - DATA: on baud_tick, if bit_cnt==DATA_BITS-1, leave DATA.
//    Otherwise shift>>=1, tx<=next bit, bit_cnt++.
//  - PARITY: tx=parity for one bit period, then STOP.
//  - STOP: tx=1. On the STOP_BITS-th tick -> IDLE, baud_en<=0, tx_done<=1 for 1 cycle.
//  - Every bit lasts exactly one baud period. Frame = 1+DATA_BITS+P+STOP_BITS periods.
//  - baud_en stays low for >=1 cycle between frames, so the counter restarts from 0 for each frame.
//    Back-to-back accept is possible in the cycle after tx_done.
//  - baud_tick in IDLE: ignored. tx_valid while busy: ignored; the in-flight word is unaffected.
//  - tx_data changes after accept have no effect.
// CONFIGURATION
//  - UART_PARITY_EN defined: PARITY state is inserted after DATA.
//    The parity bit = XOR of the data bits XOR PARITY_ODD.
//  - UART_PARITY_EN undefined: no PARITY state and no parity register; DATA goes directly to STOP.
// STRUCTURE
//  - Package uart_pkg holds:
//    - typedef enum logic [2:0] uart_tx_state_t {IDLE, START, DATA, PARITY, STOP}
//    - localparams UART_DATA_BITS_DEF=8 and UART_STOP_BITS_DEF=1
//  - No sub-module inside this block. The baud counter stays a separate instance.
//    Top-level uart_tx_top wires baud_en/baud_tick between the two.
// TESTING (bench models the baud counter: tick every 10 cycles after baud_en rises)
//  1 Reset -> tx=1, tx_ready=1, baud_en=0, busy=0, tx_done=0.
//  2 Send 0xA5, no parity -> tx = 0,1,0,1,0,0,1,0,1,1, each held 10 cycles;
//    tx_done 1 cycle after the stop tick; busy high for 100 cycles.
//  3 tx_valid held high with 0x12 then 0x34 -> 0x34 accepted the cycle after tx_done;
//    baud_en low exactly 1 cycle between the frames.
//  4 Assert rst during data bit 3 -> tx=1 and baud_en=0 in the same cycle;
//    after release, sending 0x0F is correct.
//  5 UART_PARITY_EN, PARITY_ODD=0: 0x07 -> parity bit 1; 0x03 -> parity bit 0;
//    frame is 11 periods.
//  6 baud_tick pulses in IDLE, and tx_valid=1 with new data mid-frame ->
//    no state change, and the in-flight word is transmitted unaltered.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART transmit state encoding and default frame parameters.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;
  localparam int UART_DATA_BITS_DEF = 8;
  localparam int UART_STOP_BITS_DEF = 1;
endpackage

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit sequencer gating a shared baud counter; define UART_PARITY_EN to insert a parity bit.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS_DEF,
  parameter int STOP_BITS  = UART_STOP_BITS_DEF,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 baud_en,
  input  logic                 baud_tick,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);
  localparam int CW = $clog2(DATA_BITS);

  uart_tx_state_t state, state_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [CW-1:0] bit_cnt, cnt_n;
  logic tx_n, en_n, done_n;
`ifdef UART_PARITY_EN
  logic par, par_n;
`endif

  assign tx_ready = state == IDLE;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= IDLE;
      tx      <= 1'b1;
      baud_en <= 1'b0;
      busy    <= 1'b0;
      tx_done <= 1'b0;
      bit_cnt <= '0;
      shift   <= '0;
`ifdef UART_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      tx      <= tx_n;
      baud_en <= en_n;
      busy    <= state_n != IDLE;
      tx_done <= done_n;
      bit_cnt <= cnt_n;
      shift   <= shift_n;
`ifdef UART_PARITY_EN
      par     <= par_n;
`endif
    end

  always_comb begin
    state_n = state;
    tx_n    = tx;
    en_n    = baud_en;
    done_n  = 1'b0;
    cnt_n   = bit_cnt;
    shift_n = shift;
`ifdef UART_PARITY_EN
    par_n   = par;
`endif
    case (state)
      IDLE: if (tx_valid) begin
        state_n = START;
        tx_n    = 1'b0;
        en_n    = 1'b1;
        shift_n = tx_data;
`ifdef UART_PARITY_EN
        par_n   = ^tx_data ^ 1'(PARITY_ODD);
`endif
      end
      START: if (baud_tick) begin
        state_n = DATA;
        tx_n    = shift[0];
        cnt_n   = '0;
      end
      DATA: if (baud_tick) begin
        if (bit_cnt == CW'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
          state_n = PARITY;
          tx_n    = par;
`else
          state_n = STOP;
          tx_n    = 1'b1;
          cnt_n   = '0;
`endif
        end else begin
          shift_n = shift >> 1;
          tx_n    = shift[1];
          cnt_n   = bit_cnt + 1'b1;
        end
      end
`ifdef UART_PARITY_EN
      PARITY: if (baud_tick) begin
        state_n = STOP;
        tx_n    = 1'b1;
        cnt_n   = '0;
      end
`endif
      STOP: if (baud_tick) begin
        // bit_cnt is reused to count stop bits
        if (bit_cnt == CW'(STOP_BITS - 1)) begin
          state_n = IDLE;
          en_n    = 1'b0;
          done_n  = 1'b1;
          cnt_n   = '0;
        end else begin
          cnt_n = bit_cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
        en_n    = 1'b0;
      end
    endcase
  end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: directed bench with a baud counter model ticking every 10 cycles while baud_en is high.
module tb_uart_tx_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] tx_data = '0;
  logic tx_valid = 1'b0;
  logic tx_ready, baud_en, baud_tick, tx, busy, tx_done;
  logic extra_tick = 1'b0;
  logic [3:0] bcnt;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk or posedge rst)
    if (rst) bcnt <= '0;
    else if (!baud_en || bcnt == 4'd9) bcnt <= '0;
    else bcnt <= bcnt + 4'd1;

  assign baud_tick = (baud_en && bcnt == 4'd9) || extra_tick;

  uart_tx_ctrl dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .baud_en(baud_en), .baud_tick(baud_tick), .tx(tx), .busy(busy), .tx_done(tx_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_state(input string tag);
    check({tag, " tx"}, 32'(tx), 1);
    check({tag, " tx_ready"}, 32'(tx_ready), 1);
    check({tag, " baud_en"}, 32'(baud_en), 0);
    check({tag, " busy"}, 32'(busy), 0);
  endtask

  function automatic logic [10:0] bits_of(input logic [7:0] d);
`ifdef UART_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {2'b11, d, 1'b0};
`endif
  endfunction

`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  // Call at the first negedge after the accept edge; returns at the tx_done negedge.
  task automatic frame(input string tag, input logic [10:0] bits, input int n);
    int busy_n = 0;
    for (int b = 0; b < n; b++)
      for (int c = 0; c < 10; c++) begin
        check($sformatf("%s bit%0d c%0d", tag, b, c), 32'(tx), 32'(bits[b]));
        if (c == 5) check($sformatf("%s bit%0d baud_en", tag, b), 32'(baud_en), 1);
        if (c == 5) check($sformatf("%s bit%0d tx_ready", tag, b), 32'(tx_ready), 0);
        check($sformatf("%s bit%0d no_done", tag, b), 32'(tx_done), 0);
        busy_n += int'(busy);
        @(negedge clk);
      end
    check({tag, " tx_done"}, 32'(tx_done), 1);
    check({tag, " busy cycles"}, 32'(busy_n), 32'(10 * n));
    idle_state({tag, " end"});
  endtask

  task automatic accept(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    idle_state("reset");
    check("reset tx_done", 32'(tx_done), 0);
    rst = 1'b0;
    @(negedge clk);
    idle_state("post-reset");

`ifndef UART_PARITY_EN
    accept(8'hA5);
    frame("A5", 11'b01101001010, 10);
`else
    accept(8'hA5);
    frame("A5", bits_of(8'hA5), NBITS);
`endif
    @(negedge clk);
    check("A5 done pulse width", 32'(tx_done), 0);

    // back-to-back with tx_valid held and data swapped right after accept
    tx_data  = 8'h12;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_data  = 8'h34;
    frame("12", bits_of(8'h12), NBITS);
    check("gap baud_en low", 32'(baud_en), 0);
    @(negedge clk);
    tx_valid = 1'b0;
    check("b2b baud_en back", 32'(baud_en), 1);
    check("b2b tx start", 32'(tx), 0);
    check("b2b done cleared", 32'(tx_done), 0);
    frame("34", bits_of(8'h34), NBITS);
    @(negedge clk);

    // reset during data bit 3 (0xA5 bit3 = 0, so the line is low before reset)
    accept(8'hA5);
    repeat (44) @(negedge clk);
    check("pre-rst tx low", 32'(tx), 0);
    rst = 1'b1;
    #1;
    idle_state("mid-frame rst");
    check("mid-frame rst done", 32'(tx_done), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    accept(8'h0F);
    frame("0F", bits_of(8'h0F), NBITS);
    @(negedge clk);

`ifdef UART_PARITY_EN
    accept(8'h07);
    frame("07 par", {1'b1, 1'b1, 8'h07, 1'b0}, 11);
    @(negedge clk);
    accept(8'h03);
    frame("03 par", {1'b1, 1'b0, 8'h03, 1'b0}, 11);
    @(negedge clk);
`endif

    // stray ticks in IDLE
    extra_tick = 1'b1;
    repeat (3) @(negedge clk);
    extra_tick = 1'b0;
    idle_state("idle ticks");
    @(negedge clk);
    idle_state("idle ticks after");

    // new request while busy must not disturb the frame
    accept(8'h3C);
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    frame("3C", bits_of(8'h3C), NBITS);
    tx_valid = 1'b0;
    @(negedge clk);
    idle_state("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
